pci_target_controller: RTL

Bus target (device) side of the PCI-style bus; the downstream counterpart of the initiator controller. Decodes the address phase, claims the transaction with devsel, paces data phases with trdy, and serves burst reads from / accepts burst writes into a local 8x32 word store. Sits on the shared AD/C_BE/frame/irdy/devsel/trdy wires alongside the initiator and arbiter.

---
 rtl/pci_pkg.sv | 15 +
 rtl/pci_target_mem.sv | 26 ++
 rtl/pci_target_controller.sv | 116 +++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// Shared constants and state encoding for the PCI-style bus target.
package pci_pkg;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int CMD_WRITE = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_WAIT,
        S_DATA,
        S_FINISH,
        S_BUSY
    } state_t;
endpackage

// File: rtl/pci_target_mem.sv
// Local word store: one combinational read port, one byte-masked write port.
module pci_target_mem import pci_pkg::*; #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wbe_n,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; they survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (!wbe_n[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pci_target_controller.sv
// PCI-style bus target: claims its address, paces data phases with trdy and
// serves burst reads/writes against a small local store.
module pci_target_controller import pci_pkg::*; #(
    parameter logic [1:0] DEV_ID    = 2'd0,
    parameter int         DEPTH     = 8,
    parameter int         INIT_WAIT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    inout  wire  [DATA_W-1:0]        AD,
    input  logic [3:0]               C_BE,
    input  logic                     frame,
    input  logic                     irdy,
    output logic                     devsel,
    output logic                     trdy,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     hit
);
    localparam int PTR_W = $clog2(DEPTH);

    state_t            state, state_n;
    logic              cmd, cmd_n;
    logic [PTR_W-1:0]  ptr, ptr_n;
    logic [1:0]        wait_cnt, wait_cnt_n;
    logic              hit_n;
    logic              frame_q;
    logic              start, addr_hit, idle, mem_we, bus_oe, ad_oe;
    logic [DATA_W-1:0] rdata;

    assign start    = !frame && frame_q;
    assign addr_hit = (AD == {{(DATA_W-2){1'b0}}, DEV_ID});
    assign idle     = (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cmd      <= 1'b0;
            ptr      <= '0;
            wait_cnt <= '0;
            hit      <= 1'b0;
            frame_q  <= 1'b1;
        end else begin
            state    <= state_n;
            cmd      <= cmd_n;
            ptr      <= ptr_n;
            wait_cnt <= wait_cnt_n;
            hit      <= hit_n;
            frame_q  <= frame;
        end
    end

    always_comb begin
        state_n    = state;
        cmd_n      = cmd;
        ptr_n      = ptr;
        wait_cnt_n = wait_cnt;
        hit_n      = hit;
        case (state)
            S_IDLE: begin
                if (start && addr_hit) begin
                    cmd_n      = C_BE[CMD_WRITE];
                    ptr_n      = '0;
                    hit_n      = 1'b1;
                    wait_cnt_n = 2'(INIT_WAIT);
                    if (!C_BE[CMD_WRITE]) state_n = S_TURN;
                    else                  state_n = (INIT_WAIT > 0) ? S_WAIT : S_DATA;
                end else if (start) begin
                    state_n = S_BUSY;
                end
            end
            S_TURN: state_n = (INIT_WAIT > 0) ? S_WAIT : S_DATA;
            S_WAIT: begin
                wait_cnt_n = wait_cnt - 2'd1;
                if (frame && irdy) begin
                    state_n = S_FINISH;
                    hit_n   = 1'b0;
                end else if (wait_cnt == 2'd1) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (!irdy) ptr_n = (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + 1'b1;
                // frame high here is either the last phase or a master abort
                if (frame) begin
                    state_n = S_FINISH;
                    hit_n   = 1'b0;
                end
            end
            S_FINISH: state_n = S_IDLE;
            S_BUSY:   if (frame && irdy) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    assign bus_oe = (state == S_TURN) || (state == S_WAIT) ||
                    (state == S_DATA) || (state == S_FINISH);
    assign ad_oe  = !cmd && ((state == S_WAIT) || (state == S_DATA));
    assign devsel = bus_oe ? (state == S_FINISH) : 1'bz;
    assign trdy   = bus_oe ? (state != S_DATA) : 1'bz;
    assign AD     = ad_oe ? rdata : 'z;

    // Preload shares the write port; it only wins while idle.
    assign mem_we = idle ? ld_en : (state == S_DATA && cmd && !irdy);

    pci_target_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idle ? ld_addr : ptr),
        .wdata (idle ? ld_data : AD),
        .wbe_n (idle ? 4'b0000 : C_BE),
        .raddr (ptr),
        .rdata (rdata)
    );
endmodule
